// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and baud derivation; UART_RX_PARITY_EN adds PARITY state
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
`endif

    function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    function automatic int half_bit(input int cnt_max);
        return cnt_max / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte port toward the picture RAM write stage
interface uart_rx_if;
    logic [7:0] po_data;
    logic       po_flag;
    logic       rx_err;

    modport master (output po_data, output po_flag, output rx_err);
    modport slave  (input  po_data, input  po_flag, input  rx_err);
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser plus falling-edge detect for the rx pin
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic rx_reg1;
    logic rx_reg2;
    logic rx_reg3;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_reg1 <= 1'b1;
            rx_reg2 <= 1'b1;
            rx_reg3 <= 1'b1;
        end else begin
            rx_reg1 <= rx;
            rx_reg2 <= rx_reg1;
            rx_reg3 <= rx_reg2;
        end
    end

    assign rx_s    = rx_reg2;
    assign rx_fall = rx_reg3 & ~rx_reg2;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1; define UART_RX_PARITY_EN for 8E1 with parity check
module uart_rx
    import uart_pkg::*;
#(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic      sys_clk,
    input  logic      sys_rst,
    input  logic      rx,
    uart_rx_if.master rx_if
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int HALF_BIT     = half_bit(BAUD_CNT_MAX);
    localparam int CNT_W        = $clog2(BAUD_CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_BIT - 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    uart_state_t      state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic [7:0]       po_data;
    logic             po_flag;
    logic             rx_err;
    logic             baud_end;
    logic             mid_bit;
    logic             frame_ok;

    assign baud_end = (baud_cnt == CNT_LAST);
    assign mid_bit  = (baud_cnt == CNT_MID);

`ifdef UART_RX_PARITY_EN
    logic par_err;
    assign frame_ok = rx_s & ~par_err;
`else
    assign frame_ok = rx_s;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            po_data   <= '0;
            po_flag   <= 1'b0;
            rx_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            po_flag <= 1'b0;
            rx_err  <= 1'b0;

            if (state == IDLE || baud_end)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (rx_fall)
                        state <= START;
                end
                START: begin
                    if (mid_bit && rx_s) begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                    end else if (baud_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (mid_bit)
                        shift_reg <= {rx_s, shift_reg[7:1]};
                    if (baud_end) begin
                        if (bit_cnt == 3'd7)
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    // Even parity: the parity bit makes the total count of ones even.
                    if (mid_bit)
                        par_err <= (rx_s != ^shift_reg);
                    if (baud_end)
                        state <= STOP;
                end
`endif
                STOP: begin
                    // Leave at mid-bit so a start bit right after the stop bit is not missed.
                    if (mid_bit) begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                        if (frame_ok) begin
                            po_data <= shift_reg;
                            po_flag <= 1'b1;
                        end else begin
                            rx_err  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_if.po_data = po_data;
    assign rx_if.po_flag = po_flag;
    assign rx_if.rx_err  = rx_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: vector table, scoreboard, corner sequences
module tb_uart_rx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int UART_BPS = 781_250;
    localparam int N        = CLK_FREQ / UART_BPS;
    localparam int H        = N / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PRE_STOP = 10;
`else
    localparam int PRE_STOP = 9;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic rx      = 1'b1;

    uart_rx_if rx_if ();

    uart_rx #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .rx      (rx),
        .rx_if   (rx_if)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         when;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       par_ok;
        int         gap;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[8];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_strobe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (N) @(posedge sys_clk);
        #1;
    endtask

    // Caller is aligned just after a rising edge; the frame starts immediately.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
        exp_t e;
        e.is_err = ~stop_bit;
`ifdef UART_RX_PARITY_EN
        e.is_err = e.is_err | (par_bit != ^data);
`endif
        e.data = e.is_err ? last_good : data;
        e.when = cyc + 3 + PRE_STOP * N + H;
        if (!e.is_err) last_good = data;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        if (prev_strobe)
            check("strobe_one_cycle", {31'd0, rx_if.po_flag | rx_if.rx_err}, 32'd0);
        if (!sys_rst && (rx_if.po_flag || rx_if.rx_err)) begin
            check("no_dual_strobe", {31'd0, rx_if.po_flag & rx_if.rx_err}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: po_flag=%0b rx_err=%0b po_data=%0h, want no strobe (cycle %0d)",
                         rx_if.po_flag, rx_if.rx_err, rx_if.po_data, cyc);
            end else begin
                e = sb.pop_front();
                check("strobe_is_err", {31'd0, rx_if.rx_err}, {31'd0, e.is_err});
                check("strobe_po_data", {24'd0, rx_if.po_data}, {24'd0, e.data});
                check("strobe_time", cyc, e.when);
            end
        end
        prev_strobe <= rx_if.po_flag | rx_if.rx_err;
    end

    initial begin
        vecs[0] = '{data: 8'h55, stop_bit: 1'b1, par_ok: 1'b1, gap: 4};
        vecs[1] = '{data: 8'hA3, stop_bit: 1'b0, par_ok: 1'b1, gap: 8};
        vecs[2] = '{data: 8'h0F, stop_bit: 1'b1, par_ok: 1'b1, gap: 0};
        vecs[3] = '{data: 8'hF0, stop_bit: 1'b1, par_ok: 1'b1, gap: 4};
        vecs[4] = '{data: 8'h00, stop_bit: 1'b1, par_ok: 1'b1, gap: 0};
        vecs[5] = '{data: 8'hFF, stop_bit: 1'b1, par_ok: 1'b1, gap: 3};
        vecs[6] = '{data: 8'h80, stop_bit: 1'b1, par_ok: 1'b1, gap: 0};
        vecs[7] = '{data: 8'h01, stop_bit: 1'b1, par_ok: 1'b1, gap: 6};

        repeat (4) @(negedge sys_clk);
        check("rst_po_data", {24'd0, rx_if.po_data}, 32'd0);
        check("rst_po_flag", {31'd0, rx_if.po_flag}, 32'd0);
        check("rst_rx_err", {31'd0, rx_if.rx_err}, 32'd0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        idle_cycles(10);

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_bit, (^vecs[i].data) ^ ~vecs[i].par_ok);
            if (vecs[i].gap > 0) idle_cycles(vecs[i].gap);
        end
        idle_cycles(N);
        check("table_drained", sb.size(), 32'd0);

        // Glitch shorter than half a bit must look like a false start.
        rx = 1'b0;
        repeat (20) @(posedge sys_clk);
        #1;
        idle_cycles(3 * N);
        check("glitch_po_data_held", {24'd0, rx_if.po_data}, {24'd0, last_good});
        send_frame(8'h5A, 1'b1, ^8'h5A);
        idle_cycles(N);

        // Reset during data bit 4 of 0xFF discards the frame.
        rx = 1'b0;
        repeat (N) @(posedge sys_clk);
        #1;
        rx = 1'b1;
        repeat (4 * N + H) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("abort_rst_po_data", {24'd0, rx_if.po_data}, 32'd0);
        check("abort_rst_po_flag", {31'd0, rx_if.po_flag}, 32'd0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        last_good = 8'h00;
        idle_cycles(6 * N);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        idle_cycles(4);
        check("after_abort_po_data", {24'd0, rx_if.po_data}, 32'h3C);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        idle_cycles(4);
        check("par_bad_po_data", {24'd0, rx_if.po_data}, 32'h3C);
        send_frame(8'h07, 1'b1, 1'b1);
        idle_cycles(4);
        check("par_good_po_data", {24'd0, rx_if.po_data}, 32'h07);
`endif

        for (int i = 0; i < 4 * N && sb.size() != 0; i++) @(posedge sys_clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
